spi_master_dual_tx: RTL

//  Dual-lane SPI transmitter (master) for the dual-lane 32-bit SPI slave receiver link.

---
 rtl/spi_master_dual_tx.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_dual_tx.sv
// spi_master_dual_tx: dual-lane SPI mode-0 transmitter (master).
// Sends two WORD_W-bit words per frame, MSB first and in lock-step on
// DATA_OUT0/DATA_OUT1. Each SCK level is held for HALF_PERIOD clk cycles
// so an oversampling receiver sees every edge.
//
// Ports:
//   clk, reset           system clock; synchronous active-high reset
//   en                   block enable; low aborts a frame and blocks new ones
//   start                frame request, taken only while ready is high
//   data_in0/1           lane words, captured when a frame is accepted
//   ready                IDLE && en && !reset (combinational)
//   busy                 high in every non-IDLE state (registered)
//   done                 one-cycle pulse when a frame completes normally
//   frame_cnt            count of completed frames, wraps at 16 bits
//   SCK, SSEL            serial clock and active-low select (registered)
//   DATA_OUT0/1          lane serial data (registered)

module spi_master_dual_tx #(
    parameter int WORD_W      = 32,
    parameter int HALF_PERIOD = 4,
    parameter int CS_SETUP    = 4,
    parameter int CS_HOLD     = 4,
    parameter int IDLE_GAP    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              start,
    input  logic [WORD_W-1:0] data_in0,
    input  logic [WORD_W-1:0] data_in1,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       frame_cnt,
    output logic              SCK,
    output logic              SSEL,
    output logic              DATA_OUT0,
    output logic              DATA_OUT1
);

    localparam int T01  = (HALF_PERIOD > CS_SETUP) ? HALF_PERIOD : CS_SETUP;
    localparam int T23  = (CS_HOLD > IDLE_GAP) ? CS_HOLD : IDLE_GAP;
    localparam int TMAX = (T01 > T23) ? T01 : T23;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int BW   = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [TW-1:0] LD_SETUP = TW'(CS_SETUP - 1);
    localparam logic [TW-1:0] LD_HALF  = TW'(HALF_PERIOD - 1);
    localparam logic [TW-1:0] LD_HOLD  = TW'(CS_HOLD - 1);
    // The IDLE cycle in which the next start is sampled is the last
    // SSEL-high cycle of the gap, so GAP itself runs one cycle short.
    localparam logic [TW-1:0] LD_GAP   =
        TW'((IDLE_GAP > 1) ? IDLE_GAP - 2 : 0);
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_LOW   = 3'd2;
    localparam logic [2:0] S_HIGH  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [BW-1:0]     bitcnt_q, bitcnt_d;
    logic [WORD_W-1:0] sh0_q, sh0_d;
    logic [WORD_W-1:0] sh1_q, sh1_d;
    logic              sck_q, sck_d;
    logic              ssel_q, ssel_d;
    logic              busy_q;
    logic              done_q, done_d;
    logic              abort_q, abort_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              accept;

    assign ready  = (state_q == S_IDLE) && en && !reset;
    assign accept = start && ready;

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        bitcnt_d = bitcnt_q;
        sh0_d    = sh0_q;
        sh1_d    = sh1_q;
        sck_d    = sck_q;
        ssel_d   = ssel_q;
        done_d   = 1'b0;
        abort_d  = abort_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_SETUP;
                    tcnt_d   = LD_SETUP;
                    bitcnt_d = '0;
                    sh0_d    = data_in0;
                    sh1_d    = data_in1;
                    sck_d    = 1'b0;
                    ssel_d   = 1'b0;
                    abort_d  = 1'b0;
                end
            end
            S_SETUP: begin
                if (tcnt_q == '0) begin
                    state_d = S_LOW;
                    tcnt_d  = LD_HALF;
                end else begin
                    tcnt_d = tcnt_q - 1'b1;
                end
            end
            S_LOW: begin
                if (tcnt_q == '0) begin
                    state_d = S_HIGH;
                    tcnt_d  = LD_HALF;
                    sck_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q - 1'b1;
                end
            end
            S_HIGH: begin
                if (tcnt_q == '0) begin
                    sck_d = 1'b0;
                    if (bitcnt_q == LAST_BIT) begin
                        state_d = S_HOLD;
                        tcnt_d  = LD_HOLD;
                    end else begin
                        // next bit lands on the same edge SCK falls
                        state_d  = S_LOW;
                        tcnt_d   = LD_HALF;
                        bitcnt_d = bitcnt_q + 1'b1;
                        sh0_d    = {sh0_q[WORD_W-2:0], 1'b0};
                        sh1_d    = {sh1_q[WORD_W-2:0], 1'b0};
                    end
                end else begin
                    tcnt_d = tcnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (tcnt_q == '0) begin
                    state_d = S_GAP;
                    tcnt_d  = LD_GAP;
                    ssel_d  = 1'b1;
                    sh0_d   = '0;
                    sh1_d   = '0;
                end else begin
                    tcnt_d = tcnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (!en) begin
                    abort_d = 1'b1;
                end
                if (tcnt_q == '0) begin
                    state_d = S_IDLE;
                    if (!abort_q && en) begin
                        done_d = 1'b1;
                        cnt_d  = cnt_q + 16'd1;
                    end
                end else begin
                    tcnt_d = tcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                sck_d   = 1'b0;
                ssel_d  = 1'b1;
            end
        endcase

        // Disable mid-frame: release the bus at once, then still honour
        // the inter-frame gap before going idle.
        if (!en && state_q != S_IDLE && state_q != S_GAP) begin
            state_d = S_GAP;
            tcnt_d  = LD_GAP;
            sck_d   = 1'b0;
            ssel_d  = 1'b1;
            sh0_d   = '0;
            sh1_d   = '0;
            abort_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            tcnt_q   <= '0;
            bitcnt_q <= '0;
            sh0_q    <= '0;
            sh1_q    <= '0;
            sck_q    <= 1'b0;
            ssel_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            bitcnt_q <= bitcnt_d;
            sh0_q    <= sh0_d;
            sh1_q    <= sh1_d;
            sck_q    <= sck_d;
            ssel_q   <= ssel_d;
            busy_q   <= (state_d != S_IDLE);
            done_q   <= done_d;
            abort_q  <= abort_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_cnt = cnt_q;
    assign SCK       = sck_q;
    assign SSEL      = ssel_q;
    assign DATA_OUT0 = sh0_q[WORD_W-1];
    assign DATA_OUT1 = sh1_q[WORD_W-1];

endmodule
